// File: rtl/ldpc_syndrome_seq.sv
// Sequential LDPC syndrome checker: evaluates P block rows of a quasi-cyclic
// parity-check matrix per cycle against registered hard decisions.
module ldpc_syndrome_seq #(
  parameter int DATA_W     = 8,
  parameter int C          = 8,
  parameter int R          = 4,
  parameter int D          = 8,
  parameter int P          = 1,
  parameter int EARLY_EXIT = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [C*R*DATA_W-1:0]               in_mtx,
  input  logic [R*D-1:0]                      in_dec,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_fail,
  output logic [$clog2(C*D+1)-1:0]            out_weight,
  output logic [((C > 1) ? $clog2(C) : 1)-1:0] out_first,
  output logic                                out_cfg_err,
  output logic                                busy
);

  localparam int WW     = $clog2(C*D+1);
  localparam int RIW    = (C > 1) ? $clog2(C) : 1;
  localparam int GROUPS = C / P;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mtx_a [C][R];
  logic [D-1:0]      dec_a [R];
  logic [GW-1:0]     grp;
  logic [WW-1:0]     weight;
  logic [RIW-1:0]    first;
  logic              found;
  logic              cfg_err;

  logic [WW-1:0]     grp_pop;
  logic              grp_fail;
  logic [RIW-1:0]    grp_first;
  logic              grp_cfg;
  logic              last_grp;

  logic [RIW-1:0]    ridx;
  logic [DATA_W-1:0] s;
  logic [D-1:0]      row_syn;
  logic [D-1:0]      term;
  logic [2*D-1:0]    dbl;

  assign last_grp = (grp == GW'(GROUPS - 1));

  // Syndrome of the current group; a rotate-right by s is the low half of {d,d} >> s.
  always_comb begin
    grp_pop   = '0;
    grp_fail  = 1'b0;
    grp_first = '0;
    grp_cfg   = 1'b0;
    ridx      = '0;
    s         = '0;
    row_syn   = '0;
    term      = '0;
    dbl       = '0;
    for (int p = 0; p < P; p++) begin
      ridx    = RIW'(int'(grp) * P + p);
      row_syn = '0;
      for (int j = 0; j < R; j++) begin
        s    = mtx_a[ridx][j];
        dbl  = {dec_a[j], dec_a[j]};
        term = '0;
        if (s == {DATA_W{1'b1}}) begin
          term = '0;
        end else if (int'(s) < D) begin
          term = D'(dbl >> s);
        end else begin
          grp_cfg = 1'b1;
        end
        row_syn = row_syn ^ term;
      end
      grp_pop = grp_pop + WW'($countones(row_syn));
      if ((row_syn != '0) && !grp_fail) begin
        grp_fail  = 1'b1;
        grp_first = ridx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_grp || ((EARLY_EXIT != 0) && grp_fail)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp     <= '0;
      weight  <= '0;
      first   <= '0;
      found   <= 1'b0;
      cfg_err <= 1'b0;
      for (int i = 0; i < C; i++)
        for (int j = 0; j < R; j++)
          mtx_a[i][j] <= '0;
      for (int j = 0; j < R; j++)
        dec_a[j] <= '0;
    end else if ((state == IDLE) && in_valid) begin
      grp     <= '0;
      weight  <= '0;
      first   <= '0;
      found   <= 1'b0;
      cfg_err <= 1'b0;
      for (int i = 0; i < C; i++)
        for (int j = 0; j < R; j++)
          mtx_a[i][j] <= in_mtx[(i*R+j)*DATA_W +: DATA_W];
      for (int j = 0; j < R; j++)
        dec_a[j] <= in_dec[j*D +: D];
    end else if (state == RUN) begin
      grp    <= grp + 1'b1;
      weight <= weight + grp_pop;
      if (grp_fail && !found) begin
        found <= 1'b1;
        first <= grp_first;
      end
      if (grp_cfg) cfg_err <= 1'b1;
    end
  end

  assign in_ready    = (state == IDLE);
  assign busy        = (state == RUN);
  assign out_valid   = (state == DONE);
  assign out_fail    = (weight != '0);
  assign out_weight  = weight;
  assign out_first   = first;
  assign out_cfg_err = cfg_err;

endmodule

// File: tb/tb_ldpc_syndrome_seq.sv
// Bench for ldpc_syndrome_seq: three instances (default, early exit, P=4)
// checked against a row-by-row arithmetic reference model.
module tb_ldpc_syndrome_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [255:0] in_mtx;
  logic [31:0]  in_dec;
  logic         iv   [3];
  logic         ordy [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         of   [3];
  logic         oc   [3];
  logic         bz   [3];
  logic [6:0]   ow   [3];
  logic [2:0]   ofst [3];

  logic [7:0] m  [8][4];
  logic [7:0] dv [4];

  int n_checks = 0;
  int n_pass   = 0;

  ldpc_syndrome_seq #(.P(1), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_mtx(in_mtx),
    .in_dec(in_dec), .out_valid(ov[0]), .out_ready(ordy[0]), .out_fail(of[0]),
    .out_weight(ow[0]), .out_first(ofst[0]), .out_cfg_err(oc[0]), .busy(bz[0]));

  ldpc_syndrome_seq #(.P(1), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_mtx(in_mtx),
    .in_dec(in_dec), .out_valid(ov[1]), .out_ready(ordy[1]), .out_fail(of[1]),
    .out_weight(ow[1]), .out_first(ofst[1]), .out_cfg_err(oc[1]), .busy(bz[1]));

  ldpc_syndrome_seq #(.P(4), .EARLY_EXIT(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_mtx(in_mtx),
    .in_dec(in_dec), .out_valid(ov[2]), .out_ready(ordy[2]), .out_fail(of[2]),
    .out_weight(ow[2]), .out_first(ofst[2]), .out_cfg_err(oc[2]), .busy(bz[2]));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++)
        in_mtx[(i*4+j)*8 +: 8] = m[i][j];
    for (int j = 0; j < 4; j++)
      in_dec[j*8 +: 8] = dv[j];
  endtask

  task automatic setAll(input logic [7:0] sv);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++)
        m[i][j] = sv;
    for (int j = 0; j < 4; j++)
      dv[j] = 8'h00;
  endtask

  // Reference: term bit k = dec[(k+s) mod 8]; rows grouped pp at a time.
  function automatic void refModel(input int pp, input bit ee, output int lat,
                                   output int wt, output int fst, output bit cfg);
    int  syn [8];
    bit  rcfg [8];
    bit  found;
    bit  gf;
    int  sh;
    lat = 0; wt = 0; fst = 0; cfg = 0; found = 0;
    for (int i = 0; i < 8; i++) begin
      syn[i] = 0;
      rcfg[i] = 0;
      for (int j = 0; j < 4; j++) begin
        sh = int'(m[i][j]);
        if (sh == 255) continue;
        if (sh >= 8) begin
          rcfg[i] = 1;
          continue;
        end
        for (int k = 0; k < 8; k++)
          if (dv[j][(k + sh) % 8]) syn[i] = syn[i] ^ (1 << k);
      end
    end
    for (int g = 0; g < 8 / pp; g++) begin
      lat++;
      gf = 0;
      for (int p = 0; p < pp; p++) begin
        int i;
        i = g * pp + p;
        wt += $countones(syn[i]);
        if (rcfg[i]) cfg = 1;
        if (syn[i] != 0) begin
          gf = 1;
          if (!found) begin
            found = 1;
            fst = i;
          end
        end
      end
      if (ee && gf) break;
    end
  endfunction

  task automatic runTxn(input int k, input int e_lat, input int e_w, input int e_first,
                        input bit e_cfg, input int hold);
    int cyc;
    @(negedge clk);
    checkOutput($sformatf("d%0d ready_idle", k), ir[k], 1);
    applyStimulus();
    iv[k] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput($sformatf("d%0d busy_run", k), bz[k], 1);
    in_mtx = {8{$urandom()}};
    in_dec = $urandom();
    cyc = 0;
    while (!ov[k] && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    iv[k] = 1'b0;
    checkOutput($sformatf("d%0d latency", k), cyc, e_lat);
    checkOutput($sformatf("d%0d weight", k), ow[k], e_w);
    checkOutput($sformatf("d%0d fail", k), of[k], (e_w != 0));
    checkOutput($sformatf("d%0d first", k), ofst[k], e_first);
    checkOutput($sformatf("d%0d cfg_err", k), oc[k], e_cfg);
    checkOutput($sformatf("d%0d busy_done", k), bz[k], 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("d%0d hold_valid", k), ov[k], 1);
      checkOutput($sformatf("d%0d hold_ready", k), ir[k], 0);
      checkOutput($sformatf("d%0d hold_weight", k), ow[k], e_w);
      checkOutput($sformatf("d%0d hold_first", k), ofst[k], e_first);
      checkOutput($sformatf("d%0d hold_cfg", k), oc[k], e_cfg);
    end
    @(negedge clk);
    ordy[k] = 1'b1;
    @(posedge clk);
    #1;
    ordy[k] = 1'b0;
    checkOutput($sformatf("d%0d valid_drop", k), ov[k], 0);
    checkOutput($sformatf("d%0d ready_back", k), ir[k], 1);
  endtask

  task automatic runModel(input int k, input int hold);
    int lat, wt, fst;
    bit cfg;
    refModel((k == 2) ? 4 : 1, (k == 1), lat, wt, fst, cfg);
    runTxn(k, lat, wt, fst, cfg, hold);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0;
      ordy[k] = 1'b0;
    end
    in_mtx = '0;
    in_dec = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("d%0d rst_ready", k), ir[k], 1);
      checkOutput($sformatf("d%0d rst_valid", k), ov[k], 0);
      checkOutput($sformatf("d%0d rst_weight", k), ow[k], 0);
      checkOutput($sformatf("d%0d rst_first", k), ofst[k], 0);
    end

    $display("[TB] directed cases");
    setAll(8'h00);
    runTxn(0, 8, 0, 0, 0, 0);

    setAll(8'hFF);
    m[0][0] = 8'h01;
    dv[0] = 8'h01;
    runTxn(0, 8, 1, 0, 0, 0);

    setAll(8'hFF);
    m[3][0] = 8'h02;
    m[3][1] = 8'h02;
    dv[0] = 8'hA5;
    dv[1] = 8'hA5;
    runTxn(0, 8, 0, 0, 0, 0);

    setAll(8'hFF);
    m[2][0] = 8'h00;
    dv[0] = 8'h3C;
    runTxn(1, 3, 4, 2, 0, 0);

    setAll(8'hFF);
    m[0][1] = 8'h09;
    runTxn(1, 8, 0, 0, 1, 0);
    runTxn(0, 8, 0, 0, 1, 0);

    setAll(8'hFF);
    m[0][2] = 8'h03;
    dv[2] = 8'h81;
    m[5][0] = 8'h09;
    runTxn(1, 1, 2, 0, 0, 0);

    setAll(8'hFF);
    m[6][3] = 8'h05;
    dv[3] = 8'h0F;
    runTxn(0, 8, 4, 6, 0, 5);
    runTxn(2, 2, 4, 6, 0, 3);

    $display("[TB] reset during run");
    setAll(8'hFF);
    m[0][0] = 8'h00;
    m[0][1] = 8'h0A;
    dv[0] = 8'hFF;
    applyStimulus();
    @(negedge clk);
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst valid", ov[0], 0);
    checkOutput("midrst busy", bz[0], 0);
    checkOutput("midrst weight", ow[0], 0);
    checkOutput("midrst fail", of[0], 0);
    checkOutput("midrst first", ofst[0], 0);
    checkOutput("midrst cfg", oc[0], 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst ready", ir[0], 1);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (ov[0]) seen++;
    end
    checkOutput("midrst no_result", seen, 0);
    setAll(8'hFF);
    m[4][2] = 8'h07;
    dv[2] = 8'h11;
    runTxn(0, 8, 2, 4, 0, 0);

    $display("[TB] randomized cases");
    for (int rep = 0; rep < 18; rep++) begin
      int rv;
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 4; j++) begin
          rv = $urandom_range(0, 19);
          if (rv < 9)       m[i][j] = 8'hFF;
          else if (rv < 19) m[i][j] = 8'($urandom_range(0, 7));
          else              m[i][j] = 8'($urandom_range(8, 254));
        end
      for (int j = 0; j < 4; j++)
        dv[j] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom());
      runModel(rep % 3, (rep % 5 == 0) ? 2 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ldpc_syndrome_seq.md
LDPC_SYNDROME_SEQ -- requirements
Module: ldpc_syndrome_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of one circulant shift value.
REQ-002 SHALL have parameter C, default 8: number of block rows (check groups).
REQ-003 SHALL have parameter R, default 4: number of block columns.
REQ-004 SHALL have parameter D, default 8: circulant size in bits.
REQ-005 SHALL have parameter P, default 1: block rows processed per cycle; C divisible by P.
REQ-006 SHALL have parameter EARLY_EXIT, default 0: 1 = stop at first failing group.
REQ-007 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-008 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port in_valid, input, 1: codeword and matrix offered.
REQ-010 SHALL have port in_ready, output, 1: block can accept.
REQ-011 SHALL have port in_mtx, input, C*R*DATA_W: shift for block (i,j) at bits [(i*R+j)*DATA_W +: DATA_W].
REQ-012 SHALL have port in_dec, input, R*D: hard decisions, block column j at bits [j*D +: D].
REQ-013 SHALL have port out_valid, output, 1: result available.
REQ-014 SHALL have port out_ready, input, 1: consumer takes result.
REQ-015 SHALL have port out_fail, output, 1: syndrome nonzero.
REQ-016 SHALL have port out_weight, output, clog2(C*D+1): syndrome popcount.
REQ-017 SHALL have port out_first, output, max(1,clog2(C)): index of first failing block row.
REQ-018 SHALL have port out_cfg_err, output, 1: an illegal shift value was seen.
REQ-019 SHALL have port busy, output, 1: high in RUN.

Function
REQ-020 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; in_ready = (state==IDLE).
REQ-021 SHALL, on in_valid&&in_ready, register in_mtx and in_dec, clear accumulators, set group index 0, enter RUN.
REQ-022 SHALL, each RUN cycle, evaluate block rows g*P..g*P+P-1 from registered copies only.
REQ-023 SHALL form block (i,j) term as shift s all-ones -> zero; s<D -> t[k]=dec_j[(k+s) mod D] (rotate right by s); D<=s<all-ones -> zero and set cfg_err.
REQ-024 SHALL form row-i syndrome as bitwise XOR over j of block terms (D bits).
REQ-025 SHALL add popcount of all P row syndromes to weight each cycle; no overflow by width choice.
REQ-026 SHALL latch out_first as lowest failing row index, only on first failure of the codeword.
REQ-027 SHALL enter DONE after group C/P-1, i.e. out_valid high C/P cycles after the accepting edge.
REQ-028 SHALL, with EARLY_EXIT=1, enter DONE on the edge closing the first group with a nonzero syndrome; weight counts groups processed so far.
REQ-029 SHALL hold out_* stable in DONE until out_valid&&out_ready, then return to IDLE; no new accept in that same cycle.
REQ-030 SHALL drive out_fail = (weight!=0); out_first = 0 when pass.
REQ-031 SHALL ignore in_valid and in_* changes outside IDLE.

Reset
REQ-032 SHALL, on rst high at any time incl. mid-RUN, go to IDLE immediately; out_valid=0, out_fail=0, out_weight=0, out_first=0, out_cfg_err=0, busy=0; in_ready=1 after release.
REQ-033 SHALL discard any in-flight codeword on reset; no result is produced for it.

Verification
REQ-034 SHALL test defaults, all shifts 0, in_dec=0 -> out_valid at +8 cycles, fail=0, weight=0, first=0.
REQ-035 SHALL test all shifts 0xFF except (0,0)=1, dec col0=8'h01 -> syndrome row0=8'h80, fail=1, weight=1, first=0, cfg_err=0.
REQ-036 SHALL test row 3 shifts (3,0)=2,(3,1)=2, others 0xFF, cols 0,1 = 8'hA5 -> XOR cancels, fail=0, weight=0.
REQ-037 SHALL test EARLY_EXIT=1, only row 2 failing, P=1 -> out_valid at +3 cycles, first=2; shift 0x09 anywhere -> cfg_err=1.
REQ-038 SHALL test out_ready held low 5 cycles in DONE -> outputs and out_valid unchanged, in_ready=0; P=4 -> latency 2.
REQ-039 SHALL test rst pulsed at RUN cycle 3 -> out_valid never asserts; next codeword returns correct result.
